// File: rtl/demux_router_pkg.sv
// Shared types for the demux_router slice: FSM state encoding and the wait-counter width helper.
package demux_router_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  // Bits needed to count from 0 up to and including limit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/demux_router_sel_decoder.sv
// Binary select to one-hot sink decode with an in-range flag. Purely combinational.
module demux_router_sel_decoder #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned NUM_OUT = 8
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic [NUM_OUT-1:0] onehot,
  output logic               in_range
);

  always_comb begin
    in_range = (32'(sel) < NUM_OUT);
    onehot   = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      onehot[i] = en && (32'(sel) == i);
    end
  end

endmodule

// File: rtl/demux_router.sv
// One-deep registered demultiplexer: routes a valid/ready beat to the sink chosen by in_sel.
// Define DEMUX_TIMEOUT_EN to drop beats whose sink stays not-ready for TIMEOUT cycles.
module demux_router
  import demux_router_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned NUM_OUT = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               err
);

  if (TIMEOUT < 1 || NUM_OUT < 1 || NUM_OUT > (1 << SEL_W)) begin : gen_param_check
    $error("demux_router: illegal TIMEOUT/NUM_OUT/SEL_W combination");
  end

  state_e             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [WIDTH-1:0]   data_q;
  logic               err_q;

  logic               hold;
  logic [NUM_OUT-1:0] sel_onehot;
  logic               sel_q_ok;
  logic               in_sel_ok;
  logic               sink_ready;
  logic               accept;
  logic               retire;
  logic               timeout;

  assign hold = (state_q == StHold);

  demux_router_sel_decoder #(
    .SEL_W   (SEL_W),
    .NUM_OUT (NUM_OUT)
  ) u_sel_decoder (
    .sel      (sel_q),
    .en       (hold),
    .onehot   (sel_onehot),
    .in_range (sel_q_ok)
  );

  // sel_q is only ever loaded with in-range values; the gate keeps out_valid one-hot regardless.
  assign out_valid  = sel_q_ok ? sel_onehot : '0;
  assign sink_ready = |(out_valid & out_ready);
  assign retire     = hold & sink_ready;
  assign in_ready   = ~hold | sink_ready;
  assign accept     = in_valid & in_ready;
  assign in_sel_ok  = (32'(in_sel) < NUM_OUT);
  assign out_data   = data_q;
  assign err        = err_q;

`ifdef DEMUX_TIMEOUT_EN
  localparam int unsigned CntW = cnt_width(TIMEOUT);

  logic [CntW-1:0] cnt_q;

  // Fires on the TIMEOUT-th stalled HOLD cycle; a same-cycle retire suppresses it.
  assign timeout = hold & ~sink_ready & (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if ((accept & in_sel_ok) | retire | timeout) begin
      cnt_q <= '0;
    end else if (hold) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (accept & ~in_sel_ok) | timeout;
      if (accept & in_sel_ok) begin
        state_q <= StHold;
        sel_q   <= in_sel;
        data_q  <= in_data;
      end else if (retire | timeout) begin
        state_q <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_demux_router.sv
// Self-checking bench for demux_router (NUM_OUT=6 so bad selects are exercised).
module tb_demux_router;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned NUM_OUT = 6;
  localparam int unsigned TIMEOUT = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic [WIDTH-1:0]   in_data;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               err;

  localparam logic [NUM_OUT-1:0] AllRdy = '1;

  always #5 clk = ~clk;

  demux_router #(
    .WIDTH   (WIDTH),
    .SEL_W   (SEL_W),
    .NUM_OUT (NUM_OUT),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err)
  );

  typedef struct {
    int         sel;
    logic [7:0] data;
  } beat_t;

  beat_t sb[$];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model state
  logic       m_hold;
  int         m_sel;
  logic [7:0] m_data;
  logic       m_err;
  int         m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_valid;
    exp_valid = m_hold ? (32'd1 << m_sel) : 32'd0;
    check_eq("out_valid", 32'(out_valid), exp_valid);
    check_eq("out_data", 32'(out_data), 32'(m_data));
    check_eq("err", 32'(err), 32'(m_err));
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;
    repeat (cycles) @(negedge clk);
    rst    = 1'b0;
    m_hold = 1'b0;
    m_sel  = 0;
    m_data = '0;
    m_err  = 1'b0;
    m_cnt  = 0;
    sb.delete();
    #1;
    check_outputs();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Called at a negedge: drive one cycle of stimulus, check, advance model and clock.
  task automatic step(input logic v, input int s, input logic [7:0] d, input logic [5:0] r);
    logic  exp_rdy, acc, good, ret, tmo;
    beat_t b;
    in_valid  = v;
    in_sel    = 3'(s);
    in_data   = d;
    out_ready = r;
    #1;
    exp_rdy = !m_hold || r[m_sel];
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (|(out_valid & out_ready)) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        b = sb.pop_front();
        check_eq("retire_sink", 32'(out_valid), 32'd1 << b.sel);
        check_eq("retire_data", 32'(out_data), 32'(b.data));
      end
    end
    acc  = v && exp_rdy;
    good = (s < NUM_OUT);
    ret  = m_hold && r[m_sel];
`ifdef DEMUX_TIMEOUT_EN
    tmo = m_hold && !r[m_sel] && (m_cnt == TIMEOUT - 1);
`else
    tmo = 1'b0;
`endif
    m_err = (acc && !good) || tmo;
    if (acc && good) begin
      m_hold = 1'b1;
      m_sel  = s;
      m_data = d;
      m_cnt  = 0;
      b.sel  = s;
      b.data = d;
      sb.push_back(b);
    end else if (ret || tmo) begin
      if (tmo) void'(sb.pop_front());
      m_hold = 1'b0;
      m_cnt  = 0;
    end else if (m_hold) begin
      m_cnt++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    do_reset(2);

    // Single beat to sink 5
    step(1'b1, 5, 8'hA5, AllRdy);
    check_eq("single_valid", 32'(out_valid), 32'h20);
    check_eq("single_data", 32'(out_data), 32'hA5);
    step(1'b0, 0, 8'h00, AllRdy);
    step(1'b0, 0, 8'h00, AllRdy);

    // Stall on sink 2; competing beat must be ignored while stalled
    step(1'b1, 2, 8'h3C, 6'b111011);
    for (int i = 0; i < 4; i++) step(1'b1, 4, 8'hFF, 6'b111011);
    check_eq("stall_data", 32'(out_data), 32'h3C);
    step(1'b0, 0, 8'h00, AllRdy);

    // Streaming sel 0..7: 6 and 7 are out of range and raise err
    for (int i = 0; i < 8; i++) step(1'b1, i, 8'(8'h10 + i), AllRdy);
    step(1'b0, 0, 8'h00, AllRdy);

    // Isolated bad select
    step(1'b1, 7, 8'h77, AllRdy);
    check_eq("badsel_err", 32'(err), 32'd1);
    step(1'b0, 0, 8'h00, AllRdy);
    check_eq("badsel_err_clr", 32'(err), 32'd0);

`ifdef DEMUX_TIMEOUT_EN
    // Drop on 3rd HOLD cycle, then retire exactly on the 3rd cycle
    step(1'b1, 1, 8'h11, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 8'h00, '0);
    check_eq("tmo_err", 32'(err), 32'd1);
    step(1'b1, 1, 8'h22, '0);
    step(1'b0, 0, 8'h00, '0);
    step(1'b0, 0, 8'h00, '0);
    step(1'b0, 0, 8'h00, 6'b000010);
    check_eq("tmo_retire_err", 32'(err), 32'd0);
`endif

    // Reset while holding a beat
    step(1'b1, 3, 8'h5A, '0);
    step(1'b0, 0, 8'h00, '0);
    do_reset(2);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 8'($urandom),
           6'($urandom));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 0, 8'h00, AllRdy);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
